parking_ctrl: RTL and testbench

- Gate/slot controller for the parking system.
- Consumes the keypad decoder's registered key value and press flag, and drives the decoder's stby enable.
- Keeps per-slot occupancy and sequences entry/exit requests into a timed gate-open pulse or a timed error indication.
- Sits between the keypad decoder and the display/gate drivers.

---
 rtl/parking_pkg.sv | 14 +
 rtl/hold_timer.sv | 33 +++
 rtl/parking_ctrl.sv | 112 +++++++++++
 tb/tb_parking_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate/slot controller.
package parking_pkg;

    localparam int SLOT_W            = 4;
    localparam int DEFAULT_NUM_SLOTS = 6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GATE     = 2'd1,
        ST_ERR      = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

endpackage

// File: rtl/hold_timer.sv
// Counts 0..length-1 after a start pulse and flags the final count with a one-cycle done.
// The count parks at zero when idle so it never wraps.
module hold_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] length,
    output logic         done
);

    logic [W-1:0] count;
    logic         running;

    assign done = running && (count == length - W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            count   <= '0;
            running <= 1'b1;
        end else if (done) begin
            count   <= '0;
            running <= 1'b0;
        end else if (running) begin
            count   <= count + W'(1);
        end
    end

endmodule

// File: rtl/parking_ctrl.sv
// Gate/slot controller: turns keypad presses into entry/exit requests, tracks occupancy,
// and holds either the gate or the error indicator for a fixed number of cycles.
module parking_ctrl
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS   = DEFAULT_NUM_SLOTS,
    parameter int GATE_CYCLES = 100_000_000,
    parameter int ERR_CYCLES  = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SLOT_W-1:0]    key_value,
    input  logic                 key_press,
    input  logic                 mode_exit,
    output logic                 stby,
    output logic [NUM_SLOTS-1:0] slot_occ,
    output logic [SLOT_W-1:0]    free_count,
    output logic                 gate_open,
    output logic                 err,
    output logic [SLOT_W-1:0]    last_slot,
    output logic [1:0]           state_dbg
);

    localparam int TIMER_MAX = (GATE_CYCLES > ERR_CYCLES) ? GATE_CYCLES : ERR_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] GATE_LEN = TIMER_W'(GATE_CYCLES);
    localparam logic [TIMER_W-1:0] ERR_LEN  = TIMER_W'(ERR_CYCLES);

    state_t                 state, state_next;
    logic                   press_q;
    logic [NUM_SLOTS-1:0]   slot_occ_q, slot_occ_next;
    logic [SLOT_W-1:0]      last_slot_q, last_slot_next;
    logic [SLOT_W-1:0]      occ_cnt;
    logic                   accept, key_valid, slot_hit;
    logic                   timer_start, timer_done;
    logic [TIMER_W-1:0]     timer_len;

    assign accept    = (state == ST_IDLE) && key_press && !press_q;
    assign key_valid = (key_value != '0) && (key_value <= SLOT_W'(NUM_SLOTS));
    assign timer_len = (state == ST_ERR) ? ERR_LEN : GATE_LEN;

    always_comb begin
        slot_hit = 1'b0;
        occ_cnt  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (key_value == SLOT_W'(i + 1)) slot_hit = slot_occ_q[i];
            occ_cnt = occ_cnt + SLOT_W'(slot_occ_q[i]);
        end
    end

    // A request succeeds when the slot's occupancy is the opposite of what the request produces.
    always_comb begin
        state_next     = state;
        slot_occ_next  = slot_occ_q;
        last_slot_next = last_slot_q;
        timer_start    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && key_valid) begin
                    last_slot_next = key_value;
                    timer_start    = 1'b1;
                    if (mode_exit == slot_hit) begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (key_value == SLOT_W'(i + 1)) slot_occ_next[i] = ~mode_exit;
                        end
                        state_next = ST_GATE;
                    end else begin
                        state_next = ST_ERR;
                    end
                end
            end
            ST_GATE, ST_ERR: begin
                if (timer_done) state_next = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (!key_press) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            press_q     <= 1'b0;
            slot_occ_q  <= '0;
            last_slot_q <= '0;
        end else begin
            state       <= state_next;
            press_q     <= key_press;
            slot_occ_q  <= slot_occ_next;
            last_slot_q <= last_slot_next;
        end
    end

    hold_timer #(.W(TIMER_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (timer_start),
        .length (timer_len),
        .done   (timer_done)
    );

    assign stby       = (state == ST_IDLE) || (state == ST_WAIT_REL);
    assign gate_open  = (state == ST_GATE);
    assign err        = (state == ST_ERR);
    assign slot_occ   = slot_occ_q;
    assign free_count = SLOT_W'(NUM_SLOTS) - occ_cnt;
    assign last_slot  = last_slot_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_parking_ctrl.sv
// Bench for parking_ctrl: directed vector table, hand sequences for full lot and
// mid-gate reset, then random stimulus against a request-level reference model.
module tb_parking_ctrl;
    import parking_pkg::*;

    localparam int NS = 6;
    localparam int GC = 4;
    localparam int EC = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    key_value = '0;
    logic          key_press = 1'b0;
    logic          mode_exit = 1'b0;
    logic          stby;
    logic [NS-1:0] slot_occ;
    logic [3:0]    free_count;
    logic          gate_open;
    logic          err;
    logic [3:0]    last_slot;
    logic [1:0]    state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    parking_ctrl #(.NUM_SLOTS(NS), .GATE_CYCLES(GC), .ERR_CYCLES(EC)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_value  (key_value),
        .key_press  (key_press),
        .mode_exit  (mode_exit),
        .stby       (stby),
        .slot_occ   (slot_occ),
        .free_count (free_count),
        .gate_open  (gate_open),
        .err        (err),
        .last_slot  (last_slot),
        .state_dbg  (state_dbg)
    );

    // Reference model: a lot of NS slots, a countdown of remaining hold cycles,
    // and a flag saying the current press must be released before another counts.
    bit m_occ [1:NS];
    int m_last, m_busy, m_kind;  // m_kind: 1 = gate hold, 2 = error hold
    bit m_wait, m_prev;

    task automatic model_step(input bit r, input bit kp, input int kv, input bit me);
        if (r) begin
            for (int s = 1; s <= NS; s++) m_occ[s] = 1'b0;
            m_last = 0; m_busy = 0; m_kind = 0; m_wait = 1'b0; m_prev = 1'b0;
            return;
        end
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_kind = 0;
                m_wait = 1'b1;
            end
        end else if (m_wait) begin
            if (!kp) m_wait = 1'b0;
        end else if (kp && !m_prev && kv >= 1 && kv <= NS) begin
            m_last = kv;
            if (me == m_occ[kv]) begin
                m_occ[kv] = !me;
                m_kind = 1;
                m_busy = GC;
            end else begin
                m_kind = 2;
                m_busy = EC;
            end
        end
        m_prev = kp;
    endtask

    function automatic logic [31:0] exp_occ();
        logic [31:0] v = '0;
        for (int s = 1; s <= NS; s++) v[s-1] = m_occ[s];
        return v;
    endfunction

    function automatic int exp_free();
        int n = NS;
        for (int s = 1; s <= NS; s++) n -= int'(m_occ[s]);
        return n;
    endfunction

    function automatic int exp_state();
        if (m_busy > 0) return m_kind;
        return m_wait ? 3 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".gate"},  32'(gate_open),  32'(m_busy > 0 && m_kind == 1));
        chk({tag, ".err"},   32'(err),        32'(m_busy > 0 && m_kind == 2));
        chk({tag, ".stby"},  32'(stby),       32'(m_busy == 0));
        chk({tag, ".occ"},   32'(slot_occ),   exp_occ());
        chk({tag, ".free"},  32'(free_count), 32'(exp_free()));
        chk({tag, ".last"},  32'(last_slot),  32'(m_last));
        chk({tag, ".state"}, 32'(state_dbg),  32'(exp_state()));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle for sampling.
    task automatic step(input bit r, input bit kp, input int kv, input bit me);
        rst = r; key_press = kp; key_value = 4'(kv); mode_exit = me;
        @(posedge clk);
        model_step(r, kp, kv, me);
        #1;
    endtask

    task automatic request(input int kv, input bit me);
        step(1'b0, 1'b1, kv, me);
        check_model("req_press");
        for (int i = 0; i < GC + 2; i++) begin
            step(1'b0, 1'b0, kv, me);
            check_model("req_rel");
        end
    endtask

    typedef struct packed {
        logic       rst, kp;
        logic [3:0] kv;
        logic       me, g, e, s;
        logic [5:0] occ;
        logic [3:0] free, last;
    } vec_t;

    vec_t vq[$];

    task automatic v(input int r, kp, kv, me, g, e, s, occ, fr, la);
        vec_t x;
        x.rst = 1'(r); x.kp = 1'(kp); x.kv = 4'(kv); x.me = 1'(me);
        x.g = 1'(g); x.e = 1'(e); x.s = 1'(s);
        x.occ = 6'(occ); x.free = 4'(fr); x.last = 4'(la);
        vq.push_back(x);
    endtask

    initial begin
        bit kp_r;
        //  rst kp kv me   g e s  occ  free last
        v(1, 0, 0, 0,   0, 0, 1, 'h00, 6, 0);
        v(0, 0, 3, 0,   0, 0, 1, 'h00, 6, 0);
        v(0, 1, 3, 0,   1, 0, 0, 'h04, 5, 3);  // entry 3 accepted
        v(0, 1, 3, 0,   1, 0, 0, 'h04, 5, 3);
        v(0, 1, 3, 1,   1, 0, 0, 'h04, 5, 3);
        v(0, 1, 3, 0,   1, 0, 0, 'h04, 5, 3);
        v(0, 1, 3, 0,   0, 0, 1, 'h04, 5, 3);  // held: waiting for release
        v(0, 1, 3, 0,   0, 0, 1, 'h04, 5, 3);
        v(0, 0, 3, 0,   0, 0, 1, 'h04, 5, 3);
        v(0, 1, 3, 0,   0, 1, 0, 'h04, 5, 3);  // entry to occupied slot
        v(0, 1, 3, 0,   0, 1, 0, 'h04, 5, 3);
        v(0, 1, 3, 0,   0, 1, 0, 'h04, 5, 3);
        v(0, 0, 3, 0,   0, 0, 1, 'h04, 5, 3);
        v(0, 0, 3, 1,   0, 0, 1, 'h04, 5, 3);
        v(0, 1, 3, 1,   1, 0, 0, 'h00, 6, 3);  // exit 3
        v(0, 0, 3, 1,   1, 0, 0, 'h00, 6, 3);
        v(0, 1, 5, 1,   1, 0, 0, 'h00, 6, 3);  // press during gate ignored
        v(0, 0, 5, 1,   1, 0, 0, 'h00, 6, 3);
        v(0, 0, 5, 1,   0, 0, 1, 'h00, 6, 3);
        v(0, 0, 5, 1,   0, 0, 1, 'h00, 6, 3);
        v(0, 1, 5, 1,   0, 1, 0, 'h00, 6, 5);  // exit on empty lot
        v(0, 1, 5, 1,   0, 1, 0, 'h00, 6, 5);
        v(0, 1, 5, 1,   0, 1, 0, 'h00, 6, 5);
        v(0, 1, 5, 1,   0, 0, 1, 'h00, 6, 5);
        v(0, 0, 5, 1,   0, 0, 1, 'h00, 6, 5);
        v(0, 1, 0, 0,   0, 0, 1, 'h00, 6, 5);  // key 0 ignored
        v(0, 0, 0, 0,   0, 0, 1, 'h00, 6, 5);
        v(0, 1, 7, 0,   0, 0, 1, 'h00, 6, 5);  // key 7 ignored
        v(0, 0, 7, 1,   0, 0, 1, 'h00, 6, 5);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].kp, int'(vq[i].kv), vq[i].me);
            chk($sformatf("vec%0d.gate", i), 32'(gate_open),  32'(vq[i].g));
            chk($sformatf("vec%0d.err", i),  32'(err),        32'(vq[i].e));
            chk($sformatf("vec%0d.stby", i), 32'(stby),       32'(vq[i].s));
            chk($sformatf("vec%0d.occ", i),  32'(slot_occ),   32'(vq[i].occ));
            chk($sformatf("vec%0d.free", i), 32'(free_count), 32'(vq[i].free));
            chk($sformatf("vec%0d.last", i), 32'(last_slot),  32'(vq[i].last));
        end

        // Fill the lot, then an entry must be rejected.
        for (int s = 1; s <= NS; s++) request(s, 1'b0);
        chk("full.free", 32'(free_count), 32'd0);
        chk("full.occ",  32'(slot_occ),   32'h3f);
        step(1'b0, 1'b1, 2, 1'b0);
        chk("full_entry.err",  32'(err),       32'd1);
        chk("full_entry.gate", 32'(gate_open), 32'd0);
        chk("full_entry.occ",  32'(slot_occ),  32'h3f);
        check_model("full_entry");
        for (int i = 0; i < EC + 2; i++) begin
            step(1'b0, 1'b0, 2, 1'b0);
            check_model("full_rel");
        end

        // Reset during the second gate cycle.
        step(1'b0, 1'b1, 4, 1'b1);
        chk("rstgate.gate1", 32'(gate_open), 32'd1);
        chk("rstgate.occ1",  32'(slot_occ),  32'h37);
        step(1'b0, 1'b0, 4, 1'b1);
        chk("rstgate.gate2", 32'(gate_open), 32'd1);
        step(1'b1, 1'b0, 0, 1'b0);
        chk("rstgate.gate",  32'(gate_open),  32'd0);
        chk("rstgate.occ",   32'(slot_occ),   32'd0);
        chk("rstgate.last",  32'(last_slot),  32'd0);
        chk("rstgate.free",  32'(free_count), 32'd6);
        chk("rstgate.stby",  32'(stby),       32'd1);
        chk("rstgate.state", 32'(state_dbg),  32'(ST_IDLE));

        // Random traffic against the model.
        kp_r = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int kv_r;
            if ($urandom_range(0, 2) == 0) kp_r = !kp_r;
            kv_r = int'($urandom_range(0, 9));
            step(($urandom_range(0, 399) == 0), kp_r, kv_r, 1'($urandom_range(0, 1)));
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
